if_inst_buf: RTL
================

IF_INST_BUF -- requirements
Module: if_inst_buf

Interface
REQ-001 SHALL provide: clk  input  1  single clock, all state changes on rising edge.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: inst_req  output  1  fetch request to instruction SRAM-like port.
REQ-004 SHALL provide: inst_addr  output  32  fetch byte address, word aligned.
REQ-005 SHALL provide: inst_addr_ok  input  1  request accepted when inst_req & inst_addr_ok.
REQ-006 SHALL provide: inst_data_ok  input  1  one response, returned in request order.
REQ-007 SHALL provide: inst_rdata  input  32  response word, valid with inst_data_ok.
REQ-008 SHALL provide: id_valid  output  1  head entry is presented to decode.
REQ-009 SHALL provide: id_inst  output  32  head instruction.
REQ-010 SHALL provide: id_pc  output  32  head instruction address.
REQ-011 SHALL provide: id_ready  input  1  decode accepts; pop on id_valid & id_ready (driven as ~b_stop).
REQ-012 SHALL provide: br_valid  input  1  branch/jump accepted this cycle is taken; qualified with id_valid & id_ready.
REQ-013 SHALL provide: br_target  input  32  taken target address.
REQ-014 SHALL provide: exc_flush  input  1  exception/eret flush, discards everything.
REQ-015 SHALL provide: exc_pc  input  32  restart address for exc_flush.
REQ-016 SHALL use parameter DEPTH, default 4, buffer entries; RESET_PC, default 32'hBFC0_0000.

Function
REQ-017 SHALL hold a DEPTH-entry circular FIFO of {pc, inst}, 2-bit rd/wr pointers wrapping modulo DEPTH, 3-bit count.
REQ-018 SHALL keep fetch_pc (next address to request) and a 3-bit outstanding counter (accepted, unanswered requests).
REQ-019 SHALL assert inst_req only when count + outstanding < DEPTH, not in reset, and not in the cycle of exc_flush; inst_addr = fetch_pc.
REQ-020 SHALL, on request accept, increment outstanding and set fetch_pc to fetch_pc+4 (mod 2^32); outstanding decrements on inst_data_ok.
REQ-021 SHALL push {pc of that request, inst_rdata} on inst_data_ok unless the response is marked discard; pc is tracked by a per-request pc queue or equivalent.
REQ-022 SHALL drive id_valid = (count != 0); empty buffer never presents; bypass from inst_rdata to id_* is not permitted (one-cycle minimum latency response-to-decode).
REQ-023 SHALL support push and pop in the same cycle with count unchanged; push when full is impossible by REQ-019.
REQ-024 SHALL implement delay slot on br_valid: exactly one next in-order instruction (delay slot) is kept, all later ones discarded, fetching resumes at br_target.
REQ-025 SHALL, on br_valid with buffer holding >=1 entry after the pop: keep that entry, drop the rest, mark all outstanding responses discard, fetch_pc <= br_target.
REQ-026 SHALL, on br_valid with buffer empty after pop and outstanding >=1: keep the first returning response, mark the remainder discard, fetch_pc <= br_target.
REQ-027 SHALL, on br_valid with buffer empty and outstanding 0: enter state DS_REQ, issue the delay slot request at fetch_pc, then fetch_pc <= br_target and return to RUN.
REQ-028 SHALL use states RUN, DS_REQ; discarding is a counter (discard_cnt) independent of state and decremented per discarded response.
REQ-029 SHALL, on exc_flush: count <= 0, pointers <= 0, discard_cnt <= outstanding (minus any data_ok this cycle), state <= RUN, fetch_pc <= exc_pc; next request no earlier than the following cycle.
REQ-030 SHALL give exc_flush priority over br_valid and over push in the same cycle.
REQ-031 SHALL ignore br_valid when id_valid & id_ready is false.

Reset
REQ-032 SHALL on reset: fetch_pc=RESET_PC, count, pointers, outstanding, discard_cnt = 0, state=RUN, inst_req=0, id_valid=0, id_inst=0, id_pc=0.
REQ-033 SHALL on reset mid-operation drop in-flight requests; memory side is reset concurrently, so no responses arrive after reset.

Verification
REQ-034 Reset release, addr_ok=data_ok=1 each cycle, id_ready=1 -> requests 0xBFC00000, +4, +8...; id_pc sequence identical, first id_valid 2 cycles after first accept.
REQ-035 id_ready=0 for 10 cycles -> count reaches 4, inst_req deasserts, no lost/duplicated entries after id_ready returns.
REQ-036 Branch at 0xBFC00010 accepted, buffer holds 0x14,0x18 -> next id_pc 0x14 then br_target 0xBFC00100; 0x18 never presented; in-flight 0x1C/0x20 responses discarded.
REQ-037 Branch accepted with empty buffer, outstanding 0 -> one request at branch_pc+4, next request at br_target; id_pc order pc+4, target.
REQ-038 exc_flush same cycle as br_valid and data_ok, exc_pc=0xBFC00380 -> buffer empty next cycle, all pending responses discarded, first id_pc 0xBFC00380.
REQ-039 inst_data_ok delayed 3 cycles, random addr_ok -> outstanding never exceeds DEPTH-count; in-order delivery holds.

Source files
------------

// File: rtl/if_inst_buf.sv
// if_inst_buf: instruction fetch buffer sitting between an SRAM-like
// instruction port and the decode stage.
//
// It issues in-order fetch requests, keeps the responses in a small circular
// FIFO of {pc, inst}, and presents the head entry to decode. A taken branch
// keeps exactly one delay-slot instruction. An exception flush drops
// everything, and any responses still in flight are swallowed later.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   inst_req / inst_addr            fetch request, word-aligned byte address
//   inst_addr_ok                    request accepted when high with inst_req
//   inst_data_ok / inst_rdata       in-order response word
//   id_valid / id_inst / id_pc      head entry presented to decode
//   id_ready                        decode pops the head on id_valid & id_ready
//   br_valid / br_target            taken branch, qualified by the pop
//   exc_flush / exc_pc              flush everything, restart at exc_pc
//
// State   | meaning
// RUN     | normal sequential fetching
// DS_REQ  | branch seen with nothing buffered or in flight; the next request
//         | is the delay slot, then fetching jumps to the saved target
module if_inst_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_flush,
  input  logic [31:0] exc_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, DS_REQ = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [31:0]       buf_pc_q   [DEPTH];
  logic [31:0]       buf_inst_q [DEPTH];
  logic [31:0]       pcq_q      [DEPTH];   // pc of each outstanding request
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_cnt_q, discard_cnt_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       ds_target_q, ds_target_d;
  logic              keep_q, keep_d;       // next response is a delay slot

  logic              accept, resp_drop, push, push_wr, pop, br_take;
  logic [CW-1:0]     out_next, remain;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign inst_req  = ~reset & ~exc_flush &
                     (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_L);
  assign inst_addr = fetch_pc_q;
  assign id_valid  = (count_q != '0);
  assign id_inst   = id_valid ? buf_inst_q[rd_ptr_q] : '0;
  assign id_pc     = id_valid ? buf_pc_q[rd_ptr_q]   : '0;

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pq_rd_d       = pq_rd_q;
    pq_wr_d       = pq_wr_q;
    discard_cnt_d = discard_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    ds_target_d   = ds_target_q;
    keep_d        = keep_q;

    accept    = inst_req & inst_addr_ok;
    // A pending delay-slot keep outranks the discard counter.
    resp_drop = inst_data_ok & ~keep_q & (discard_cnt_q != '0);
    push      = inst_data_ok & ~resp_drop;
    pop       = id_valid & id_ready;
    br_take   = pop & br_valid;
    out_next  = outstanding_q + CW'(accept) - CW'(inst_data_ok);
    remain    = count_q + CW'(push) - CW'(pop);

    outstanding_d = out_next;
    count_d       = remain;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      keep_d   = 1'b0;
    end
    if (pop)          rd_ptr_d      = ptr_inc(rd_ptr_q);
    if (resp_drop)    discard_cnt_d = discard_cnt_q - 1'b1;
    if (inst_data_ok) pq_rd_d       = ptr_inc(pq_rd_q);
    if (accept) begin
      pq_wr_d    = ptr_inc(pq_wr_q);
      fetch_pc_d = (state_q == DS_REQ) ? ds_target_q : fetch_pc_q + 32'd4;
      state_d    = RUN;
    end

    if (br_take) begin
      if (remain != '0) begin
        // The new head is the delay slot; everything behind it and in flight goes.
        count_d       = CW'(1);
        wr_ptr_d      = ptr_inc(rd_ptr_d);
        discard_cnt_d = out_next;
        keep_d        = 1'b0;
        fetch_pc_d    = br_target;
      end else if (out_next != '0) begin
        keep_d        = 1'b1;
        discard_cnt_d = out_next - 1'b1;
        fetch_pc_d    = br_target;
      end else begin
        // Nothing in flight means no accept this cycle, so fetch_pc is the slot.
        state_d     = DS_REQ;
        ds_target_d = br_target;
      end
    end

    if (exc_flush) begin
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      discard_cnt_d = outstanding_q - CW'(inst_data_ok);
      keep_d        = 1'b0;
      state_d       = RUN;
      fetch_pc_d    = exc_pc;
    end
  end

  assign push_wr = push & ~exc_flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pq_rd_q       <= '0;
      pq_wr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
      fetch_pc_q    <= RESET_PC;
      ds_target_q   <= '0;
      keep_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pq_rd_q       <= pq_rd_d;
      pq_wr_q       <= pq_wr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
      fetch_pc_q    <= fetch_pc_d;
      ds_target_q   <= ds_target_d;
      keep_q        <= keep_d;
    end
  end

  // Storage arrays carry no reset; the outputs are gated by count instead.
  always_ff @(posedge clk) begin
    if (push_wr) begin
      buf_pc_q[wr_ptr_q]   <= pcq_q[pq_rd_q];
      buf_inst_q[wr_ptr_q] <= inst_rdata;
    end
    if (accept) pcq_q[pq_wr_q] <= fetch_pc_q;
  end

endmodule
